mmio_input_bridge: RTL and testbench

Memory-mapped input peripheral for the processor data bus. It is the input-side counterpart to the data RAM, which drives LEDs and mode outputs from fixed memory words. This block synchronizes and debounces the board switches and a push button, and exposes their state, edge events and change flags as four read-mostly registers at a configurable base address. An optional interrupt request flags pending input activity.

---
 rtl/mmio_input_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_mmio_input_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_input_bridge.sv
// mmio_input_bridge
// Memory-mapped input peripheral: synchronizes and debounces 16 switches and
// one push button, and exposes state, button events and switch change flags
// as four registers at BASE_ADDR..BASE_ADDR+3.
//
// Optional feature macro: MMIO_IRQ_EN
//   defined   : CONTROL register (irq_en) is implemented and irq is driven.
//   undefined : CONTROL reads 0, writes to it are ignored, irq stays 0.
//
// Register map (word offset from BASE_ADDR, unused bits read 0):
//   +0 SWITCHES [15:0] debounced SW                      (read-only)
//   +1 EVENT    [0] pending (clear on read), [15:8] press_cnt
//               (press_cnt cleared by writing 1 to bit 1)
//   +2 CHANGED  [15:0] changed mask (clear on read)
//   +3 CONTROL  [0] irq_en                               (read/write)

module mmio_input_bridge #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 12,
  parameter int BASE_ADDR       = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rEn,
  input  logic                     wEn,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  output logic [DATA_WIDTH-1:0]    dataOut,
  input  logic [15:0]              SW,
  input  logic                     BTN,
  output logic                     irq
);

  // Prescaler sizing: counts 0..DEBOUNCE_CYCLES-1.
  localparam int PW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);

  // Register offsets.
  localparam logic [1:0] OFF_SWITCHES = 2'd0;
  localparam logic [1:0] OFF_EVENT    = 2'd1;
  localparam logic [1:0] OFF_CHANGED  = 2'd2;
  localparam logic [1:0] OFF_CONTROL  = 2'd3;

  // Input vector layout: bit 16 is the button, bits 15:0 are switches.
  logic [16:0] w_raw;
  logic [16:0] r_meta;
  logic [16:0] r_sync;
  logic [16:0] r_sample;
  logic [16:0] r_deb;
  logic [PW-1:0] r_presc;

  logic        r_pending;
  logic [7:0]  r_press_cnt;
  logic [15:0] r_changed;

  logic        w_tick;
  logic [16:0] w_stable;
  logic [16:0] w_deb_next;
  logic        w_btn_rise;
  logic [15:0] w_sw_toggle;

  logic [ADDRESS_WIDTH-1:0] w_offset_full;
  logic [1:0]  w_offset;
  logic        w_hit;
  logic        w_rd;
  logic        w_rd_hit;
  logic        w_wr_hit;
  logic        w_clr_pending;
  logic        w_clr_changed;
  logic        w_clr_cnt;
  logic        w_irq_en;
  logic        w_irq_next;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic        w_unused_data;

  assign w_raw = {BTN, SW};

  // Only bits 1:0 of dataIn carry meaning; the rest are intentionally ignored.
  assign w_unused_data = ^dataIn;

  // Two-flop synchronizer for every raw input bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 17'd0;
      r_sync <= 17'd0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // Debounce prescaler: free-running 0..DEBOUNCE_CYCLES-1, tick at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

  // A bit is stable when the new sample matches the previous one; only then
  // may the debounced value follow it.
  assign w_stable    = ~(r_sync ^ r_sample);
  assign w_deb_next  = w_tick ? ((r_deb & ~w_stable) | (r_sync & w_stable)) : r_deb;
  assign w_btn_rise  = w_deb_next[16] & ~r_deb[16];
  assign w_sw_toggle = w_deb_next[15:0] ^ r_deb[15:0];

  // Tick-rate sampler and debounced state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= 17'd0;
      r_deb    <= 17'd0;
    end else if (w_tick) begin
      r_sample <= r_sync;
      r_deb    <= w_deb_next;
    end
  end

  // Address decode: offset wraps, so any address outside the 4-word window
  // has nonzero upper offset bits.
  assign w_offset_full = addr - BASE;
  assign w_offset      = w_offset_full[1:0];
  assign w_hit         = (w_offset_full[ADDRESS_WIDTH-1:2] == '0);

  // A simultaneous write wins over the read; the read then has no effect.
  assign w_rd          = rEn & ~wEn;
  assign w_rd_hit      = w_rd & w_hit;
  assign w_wr_hit      = wEn & w_hit;
  assign w_clr_pending = w_rd_hit & (w_offset == OFF_EVENT);
  assign w_clr_changed = w_rd_hit & (w_offset == OFF_CHANGED);
  assign w_clr_cnt     = w_wr_hit & (w_offset == OFF_EVENT) & dataIn[1];

`ifdef MMIO_IRQ_EN
  logic r_irq_en;

  // CONTROL register: interrupt enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
    end else if (w_wr_hit && (w_offset == OFF_CONTROL)) begin
      r_irq_en <= dataIn[0];
    end
  end

  assign w_irq_en = r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  // Button pending flag: a new edge beats a same-cycle clearing read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (w_btn_rise) begin
      r_pending <= 1'b1;
    end else if (w_clr_pending) begin
      r_pending <= 1'b0;
    end
  end

  // Saturating press counter; a press coinciding with the clear is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_press_cnt <= 8'd0;
    end else if (w_clr_cnt) begin
      r_press_cnt <= w_btn_rise ? 8'd1 : 8'd0;
    end else if (w_btn_rise && (r_press_cnt != 8'hFF)) begin
      r_press_cnt <= r_press_cnt + 8'd1;
    end
  end

  // Switch change mask: bits toggling this cycle survive a clearing read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_changed <= 16'd0;
    end else if (w_clr_changed) begin
      r_changed <= w_sw_toggle;
    end else begin
      r_changed <= r_changed | w_sw_toggle;
    end
  end

  // Read data mux; reflects register values before this cycle's updates.
  always_comb begin
    w_rdata = '0;
    case (w_offset)
      OFF_SWITCHES: w_rdata[15:0] = r_deb[15:0];
      OFF_EVENT:    w_rdata[15:0] = {r_press_cnt, 7'd0, r_pending};
      OFF_CHANGED:  w_rdata[15:0] = r_changed;
      OFF_CONTROL:  w_rdata[15:0] = {15'd0, w_irq_en};
      default:      w_rdata[15:0] = 16'd0;
    endcase
  end

  // Registered read data: updated only by a pure read, zero on a miss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataOut <= '0;
    end else if (w_rd) begin
      dataOut <= w_rd_hit ? w_rdata : '0;
    end
  end

  assign w_irq_next = w_irq_en & (r_pending | (|r_changed));

  // Registered interrupt request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= w_irq_next;
    end
  end

endmodule

// File: tb/tb_mmio_input_bridge.sv
// Self-checking bench for mmio_input_bridge (DEBOUNCE_CYCLES=4, BASE_ADDR=16).
// A behavioural model predicts dataOut and irq every cycle; directed scenarios
// add literal expectations; a randomized phase exercises the rest.

module tb_mmio_input_bridge;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int DEB = 4;

`ifdef MMIO_IRQ_EN
  localparam logic [31:0] IRQ_BUILD = 32'd1;
`else
  localparam logic [31:0] IRQ_BUILD = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rEn = 1'b0;
  logic          wEn = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dataIn = '0;
  logic [DW-1:0] dataOut;
  logic [15:0]   SW = 16'h0000;
  logic          BTN = 1'b0;
  logic          irq;

  int checks = 0;
  int failures = 0;

  mmio_input_bridge #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BASE_ADDR(16), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rEn(rEn), .wEn(wEn), .addr(addr),
    .dataIn(dataIn), .dataOut(dataOut), .SW(SW), .BTN(BTN), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [16:0] m_hist0, m_hist1;   // inputs seen at the last two edges
  logic [16:0] m_sample, m_deb;
  logic        m_pending;
  int          m_cnt;
  logic [15:0] m_changed;
  logic        m_irq_en;
  logic [31:0] m_dout;
  logic        m_irq;
  int          m_cyc;              // edges since reset release

  function automatic logic [31:0] m_reg(input int off);
    case (off)
      0: return {16'h0000, m_deb[15:0]};
      1: return {16'h0000, m_cnt[7:0], 7'h00, m_pending};
      2: return {16'h0000, m_changed};
      3: return {31'd0, m_irq_en} & IRQ_BUILD;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_hist0 = '0; m_hist1 = '0; m_sample = '0; m_deb = '0;
    m_pending = 1'b0; m_cnt = 0; m_changed = '0; m_irq_en = 1'b0;
    m_dout = '0; m_irq = 1'b0; m_cyc = 0;
  endtask

  task automatic model_step();
    logic [16:0] seen;
    logic [16:0] deb_new;
    logic        tick, rise, rd, hit, irq_new;
    logic [15:0] tog;
    int          off;
    seen    = m_hist1;             // sampler sees input from two edges ago
    m_hist1 = m_hist0;
    m_hist0 = {BTN, SW};
    tick    = ((m_cyc % DEB) == DEB - 1);
    m_cyc++;
    deb_new = m_deb;
    if (tick) begin
      for (int i = 0; i < 17; i++)
        if (seen[i] == m_sample[i]) deb_new[i] = seen[i];
      m_sample = seen;
    end
    rise    = deb_new[16] && !m_deb[16];
    tog     = deb_new[15:0] ^ m_deb[15:0];
    irq_new = (IRQ_BUILD != 0) && m_irq_en && (m_pending || (m_changed != 0));
    rd      = rEn && !wEn;
    hit     = (addr >= 12'd16) && (addr <= 12'd19);
    off     = int'(addr) - 16;
    if (rd) m_dout = hit ? m_reg(off) : 32'd0;
    if (wEn && hit && off == 3) m_irq_en = dataIn[0];
    if (wEn && hit && off == 1 && dataIn[1]) m_cnt = 0;
    if (rise && m_cnt < 255) m_cnt++;
    if (rd && hit && off == 1) m_pending = 1'b0;
    if (rise) m_pending = 1'b1;
    if (rd && hit && off == 2) m_changed = '0;
    m_changed = m_changed | tog;
    m_deb = deb_new;
    m_irq = irq_new;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_dataOut", dataOut, m_dout);
      check("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk);
    rEn = 1'b1; wEn = 1'b0; addr = a;
    @(negedge clk);
    rEn = 1'b0;
    d = dataOut;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] v, input logic with_rd);
    @(negedge clk);
    wEn = 1'b1; rEn = with_rd; addr = a; dataIn = v;
    @(negedge clk);
    wEn = 1'b0; rEn = 1'b0;
  endtask

  task automatic press(input int hi, input int lo);
    @(negedge clk);
    BTN = 1'b1;
    repeat (hi) @(negedge clk);
    BTN = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] d;

  initial begin
    SW = 16'h00A5;
    idle(3);
    check("reset_dataOut", dataOut, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    idle(20);

    // Switches high at reset show up as debounced state and as changes.
    bus_read(12'd16, d); check("sw_state", d, 32'h0000_00A5);
    bus_read(12'd18, d); check("changed_first", d, 32'h0000_00A5);
    bus_read(12'd18, d); check("changed_cleared", d, 32'h0000_0000);

    // Short glitch on BTN is rejected.
    @(negedge clk); BTN = 1'b1;
    idle(2); BTN = 1'b0;
    idle(16);
    bus_read(12'd17, d); check("glitch_event", d, 32'h0000_0000);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Three clean presses with irq enabled.
    bus_write(12'd19, 32'd1, 1'b0);
    press(20, 20);
    check("irq_after_press", {31'd0, irq}, IRQ_BUILD);
    press(20, 20);
    press(20, 20);
    bus_read(12'd17, d); check("event_3press", d, 32'h0000_0301);
    check("irq_before_drop", {31'd0, irq}, IRQ_BUILD);
    idle(1);
    check("irq_drop", {31'd0, irq}, 32'd0);
    bus_write(12'd17, 32'd2, 1'b0);
    bus_read(12'd17, d); check("cnt_cleared", d, 32'h0000_0000);

    // Saturation of the press counter.
    repeat (260) press(12, 12);
    bus_read(12'd17, d); check("cnt_saturated", d, 32'h0000_FF01);

    // Debounced edge coinciding with a read of EVENT.
    bus_write(12'd17, 32'd2, 1'b0);
    do @(negedge clk); while ((m_cyc % DEB) != 0);
    BTN = 1'b1;
    idle(7);
    rEn = 1'b1; addr = 12'd17;
    @(negedge clk);
    rEn = 1'b0;
    check("edge_same_cycle", dataOut, 32'h0000_0000);
    bus_read(12'd17, d); check("edge_next_read", d, 32'h0000_0101);
    BTN = 1'b0;
    idle(12);

    // Out-of-range read and read/write conflict.
    bus_read(12'd18, d);
    SW = 16'h00A4;
    idle(14);
    bus_read(12'd5, d);  check("miss_read", d, 32'h0000_0000);
    bus_read(12'd18, d); check("changed_kept", d, 32'h0000_0001);
    bus_read(12'd16, d); check("sw_new", d, 32'h0000_00A4);
    bus_write(12'd19, 32'd0, 1'b1);
    check("rw_hold", dataOut, 32'h0000_00A4);
    bus_read(12'd19, d); check("irq_en_written", d, 32'h0000_0000);

    // Randomized phase with a mid-run asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        rEn = 1'b0; wEn = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("midreset_dataOut", dataOut, 32'd0);
        #2 reset_n = 1'b1;
      end else begin
        if ($urandom_range(0, 39) == 0) SW = 16'($urandom);
        else if ($urandom_range(0, 29) == 0) SW[$urandom_range(0, 15)] = ~SW[0];
        if ($urandom_range(0, 14) == 0) BTN = ~BTN;
        dataIn = $urandom;
        addr = ($urandom_range(0, 8) == 0) ? 12'd5 : 12'($urandom_range(14, 21));
        case ($urandom_range(0, 9))
          0, 1, 2: begin rEn = 1'b1; wEn = 1'b0; end
          3:       begin rEn = 1'b0; wEn = 1'b1; end
          4:       begin rEn = 1'b1; wEn = 1'b1; end
          default: begin rEn = 1'b0; wEn = 1'b0; end
        endcase
      end
    end
    rEn = 1'b0; wEn = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
